// File: rtl/gt_tx_reset_seq.sv
// gt_tx_reset_seq: N-lane GT TX reset/activity sequencer in the gt_txusrclk domain.
// Delays userclk-active, synchronises reset-done, releases lanes after a hold-off and retries GT reset on timeout.
module gt_tx_reset_seq #(
  parameter int N_CH         = 2,
  parameter int ACTIVE_DELAY = 4,
  parameter int SYNC_STAGES  = 3,
  parameter int TIMEOUT      = 65535,
  parameter int REQ_LEN      = 16,
  parameter int RST_HOLD     = 8,
  parameter int CNT_W        = 8
) (
  input  logic              gt_txusrclk,
  input  logic              gt_tx_reset,
  input  logic              tx_done_async,
  input  logic [N_CH-1:0]   lane_enable,
  input  logic [N_CH-1:0]   lane_rst_req,
  output logic              userclk_tx_active,
  output logic [N_CH-1:0]   lane_tx_rst,
  output logic              gt_reset_req,
  output logic [CNT_W-1:0]  retry_count,
  output logic [1:0]        state_out,
  output logic              tx_ready
);
  localparam int AW = $clog2(ACTIVE_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int QW = $clog2(REQ_LEN + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {ACTIVATE = 2'd0, WAIT_DONE = 2'd1, RUN = 2'd2, REQ = 2'd3} state_t;
  state_t                     r_state, w_state_n;
  logic [AW-1:0]              r_act, w_act_n;
  logic [TW-1:0]              r_timer, w_timer_n;
  logic [QW-1:0]              r_req_cnt, w_req_cnt_n;
  logic [N_CH-1:0][HW-1:0]    r_hold, w_hold_n;
  logic [SYNC_STAGES-1:0]     r_sync;
  logic [N_CH-1:0]            r_en_prev, w_rst_n;
  logic [CNT_W-1:0]           w_retry_n;
  logic                       w_done, w_active_n, w_req_n, w_ready_n;
  assign w_done    = r_sync[SYNC_STAGES-1];
  assign state_out = r_state;
  always_comb begin
    w_state_n   = r_state;
    w_act_n     = r_act;
    w_timer_n   = r_timer;
    w_req_cnt_n = r_req_cnt;
    w_active_n  = userclk_tx_active;
    w_req_n     = gt_reset_req;
    w_retry_n   = retry_count;
    case (r_state)
      ACTIVATE: begin
        w_act_n = r_act + 1'b1;
        if (r_act == AW'(ACTIVE_DELAY - 1)) begin
          w_state_n  = WAIT_DONE;
          w_active_n = 1'b1;
          w_timer_n  = '0;
        end
      end
      WAIT_DONE: begin
        w_timer_n = r_timer + 1'b1;
        if (w_done) begin
          w_state_n = RUN;
          w_timer_n = '0;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_n   = REQ;
          w_timer_n   = '0;
          w_req_n     = 1'b1;
          w_req_cnt_n = '0;
          w_retry_n   = &retry_count ? retry_count : retry_count + 1'b1;
        end
      end
      RUN: begin
        w_state_n = w_done ? RUN : WAIT_DONE;
        w_timer_n = '0;
      end
      REQ: begin
        w_req_cnt_n = r_req_cnt + 1'b1;
        if (r_req_cnt == QW'(REQ_LEN - 1)) begin
          w_state_n = WAIT_DONE;
          w_req_n   = 1'b0;
          w_timer_n = '0;
        end
      end
    endcase
    // RUN entry, a soft request or a lane enable rise all (re)load the hold-off
    for (int i = 0; i < N_CH; i++) begin
      w_hold_n[i] = '0;
      if (w_state_n == RUN)
        w_hold_n[i] = (r_state != RUN || lane_rst_req[i] || (lane_enable[i] && !r_en_prev[i])) ? HW'(RST_HOLD)
                    : (r_hold[i] != '0 ? r_hold[i] - 1'b1 : '0);
      w_rst_n[i] = !(w_state_n == RUN && lane_enable[i] && w_hold_n[i] == '0);
    end
    w_ready_n = (w_state_n == RUN) && (|lane_enable) && ((w_rst_n & lane_enable) == '0);
  end
  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      r_state           <= ACTIVATE;
      r_act             <= '0;
      r_timer           <= '0;
      r_req_cnt         <= '0;
      r_hold            <= '0;
      r_sync            <= '0;
      r_en_prev         <= '0;
      userclk_tx_active <= 1'b0;
      lane_tx_rst       <= '1;
      gt_reset_req      <= 1'b0;
      retry_count       <= '0;
      tx_ready          <= 1'b0;
    end else begin
      r_state           <= w_state_n;
      r_act             <= w_act_n;
      r_timer           <= w_timer_n;
      r_req_cnt         <= w_req_cnt_n;
      r_hold            <= w_hold_n;
      // reset-done is only meaningful once the wizard sees an active user clock
      r_sync            <= {r_sync[SYNC_STAGES-2:0], tx_done_async & userclk_tx_active};
      r_en_prev         <= lane_enable;
      userclk_tx_active <= w_active_n;
      lane_tx_rst       <= w_rst_n;
      gt_reset_req      <= w_req_n;
      retry_count       <= w_retry_n;
      tx_ready          <= w_ready_n;
    end
  end
endmodule

// File: tb/tb_gt_tx_reset_seq.sv
// tb_gt_tx_reset_seq: scoreboard bench for gt_tx_reset_seq (N_CH=2, TIMEOUT=100, REQ_LEN=16, RST_HOLD=8, CNT_W=2).
module tb_gt_tx_reset_seq;
  logic       clk = 1'b0, rst = 1'b1, done = 1'b0;
  logic [1:0] en = 2'b00, rq = 2'b00;
  logic       active, greq, rdy;
  logic [1:0] lrst, retry, st;
  int         total = 0, bad = 0;
  typedef enum {F_ACT, F_RST, F_REQ, F_RETRY, F_ST, F_RDY} fld_t;
  typedef struct {fld_t f; logic [3:0] v; string nm;} exp_t;
  exp_t sb[$];
  gt_tx_reset_seq #(.N_CH(2), .ACTIVE_DELAY(4), .SYNC_STAGES(3), .TIMEOUT(100),
                    .REQ_LEN(16), .RST_HOLD(8), .CNT_W(2)) dut (
    .gt_txusrclk(clk), .gt_tx_reset(rst), .tx_done_async(done), .lane_enable(en),
    .lane_rst_req(rq), .userclk_tx_active(active), .lane_tx_rst(lrst), .gt_reset_req(greq),
    .retry_count(retry), .state_out(st), .tx_ready(rdy));
  always #5 clk = ~clk;
  function automatic logic [3:0] obs_of(fld_t f);
    case (f)
      F_ACT:   return {3'b0, active};
      F_RST:   return {2'b0, lrst};
      F_REQ:   return {3'b0, greq};
      F_RETRY: return {2'b0, retry};
      F_ST:    return {2'b0, st};
      default: return {3'b0, rdy};
    endcase
  endfunction
  task automatic push(fld_t f, int v, string nm);
    exp_t e;
    e.f = f;
    e.v = 4'(v);
    e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t e;
    logic [3:0] o;
    rst = 1'b1; done = 1'b1; en = 2'b11; rq = 2'b00;
    repeat (2) step();
    push(F_ACT, 0, "reset.active"); push(F_RST, 3, "reset.lane_tx_rst"); push(F_REQ, 0, "reset.gt_reset_req");
    push(F_RETRY, 0, "reset.retry"); push(F_ST, 0, "reset.state"); push(F_RDY, 0, "reset.tx_ready");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_of(e.f); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s got=%0h exp=%0h t=%0t", e.nm, o, e.v, $time); end
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      push(F_ACT, int'(k >= 4), "bringup.active");
      push(F_ST, k < 4 ? 0 : (k < 8 ? 1 : 2), "bringup.state");
      push(F_RST, k < 16 ? 3 : 0, "bringup.lane_tx_rst");
      push(F_RDY, int'(k >= 16), "bringup.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s edge=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
  endtask
  task automatic test_soft_req();
    exp_t e;
    logic [3:0] o;
    for (int k = 0; k < 20; k++) begin
      rq = (k == 0 || k == 5) ? 2'b10 : 2'b00;
      step();
      rq = 2'b00;
      push(F_RST, k <= 12 ? 2 : 0, "softreq.lane_tx_rst");
      push(F_RDY, int'(k > 12), "softreq.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
  endtask
  task automatic test_done_drop();
    exp_t e;
    logic [3:0] o;
    done = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      push(F_ST, k < 4 ? 2 : 1, "drop.state");
      push(F_RST, k < 4 ? 0 : 3, "drop.lane_tx_rst");
      push(F_RDY, int'(k < 4), "drop.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
    done = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      push(F_ST, j < 4 ? 1 : 2, "redone.state");
      push(F_RST, j < 12 ? 3 : 0, "redone.lane_tx_rst");
      push(F_RDY, int'(j >= 12), "redone.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s j=%0d got=%0h exp=%0h", e.nm, j, o, e.v); end
      end
    end
  endtask
  task automatic test_enable();
    exp_t e;
    logic [3:0] o;
    en = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      push(F_RST, 2, "en01.lane_tx_rst"); push(F_RDY, 1, "en01.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
    en = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      step();
      push(F_RST, 3, "en00.lane_tx_rst"); push(F_RDY, 0, "en00.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
    en = 2'b01;
    for (int k = 0; k <= 10; k++) begin
      step();
      push(F_RST, k < 8 ? 3 : 2, "reen.lane_tx_rst"); push(F_RDY, int'(k >= 8), "reen.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
  endtask
  task automatic test_async_run();
    exp_t e;
    logic [3:0] o;
    #2 rst = 1'b1; en = 2'b11; done = 1'b1;
    #1;
    push(F_ACT, 0, "arun.active"); push(F_RST, 3, "arun.lane_tx_rst"); push(F_REQ, 0, "arun.gt_reset_req");
    push(F_ST, 0, "arun.state"); push(F_RDY, 0, "arun.tx_ready");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_of(e.f); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s got=%0h exp=%0h t=%0t", e.nm, o, e.v, $time); end
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      push(F_ST, k < 4 ? 0 : (k < 8 ? 1 : 2), "arun_restart.state");
      push(F_ACT, int'(k >= 4), "arun_restart.active");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
  endtask
  task automatic test_timeout();
    exp_t e;
    logic [3:0] o;
    int r;
    bit in_req;
    rst = 1'b1; done = 1'b0; en = 2'b11;
    repeat (2) step();
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 460; k++) begin
      step();
      r = k >= 104 ? (k - 104) / 116 + 1 : 0;
      in_req = k >= 104 && ((k - 104) % 116) < 16;
      push(F_REQ, int'(in_req), "timeout.gt_reset_req");
      push(F_RETRY, r > 3 ? 3 : r, "timeout.retry");
      push(F_ST, k < 4 ? 0 : (in_req ? 3 : 1), "timeout.state");
      push(F_RDY, 0, "timeout.tx_ready");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
    #2 rst = 1'b1;
    #1;
    push(F_REQ, 0, "areq.gt_reset_req"); push(F_ST, 0, "areq.state"); push(F_RETRY, 0, "areq.retry");
    push(F_ACT, 0, "areq.active"); push(F_RST, 3, "areq.lane_tx_rst"); push(F_RDY, 0, "areq.tx_ready");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_of(e.f); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s got=%0h exp=%0h t=%0t", e.nm, o, e.v, $time); end
    end
    done = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      push(F_ST, k < 4 ? 0 : (k < 8 ? 1 : 2), "areq_restart.state");
      push(F_ACT, int'(k >= 4), "areq_restart.active");
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs_of(e.f); total++;
        if (o !== e.v) begin bad++; $display("FAIL %s k=%0d got=%0h exp=%0h", e.nm, k, o, e.v); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_soft_req();
    test_done_drop();
    test_enable();
    test_async_run();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
